// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX session engine: FSM encodings,
// ASCII/SOH byte values and the three fixed 5-byte session templates.
package fix_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CONN_REQ, S_WAIT_CONN, S_SEND_LOGON,
    S_ACTIVE, S_SEND_HB, S_SEND_LOGOUT, S_DISCONNECT
  } state_t;

  typedef enum logic [2:0] {
    P_FIELD, P_TAG1, P_TAG2, P_ARMED, P_SKIP
  } rx_state_t;

  localparam logic [7:0] SOH   = 8'h01;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_3  = 8'h33;
  localparam logic [7:0] CH_5  = 8'h35;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_A  = 8'h41;

  localparam int MSG_LEN = 5;
  typedef logic [MSG_LEN-1:0][7:0] msg_t;

  // Element [0] is the first byte on the wire.
  localparam msg_t MSG_LOGON  = {SOH, CH_A, CH_EQ, CH_5, CH_3};
  localparam msg_t MSG_HB     = {SOH, CH_0, CH_EQ, CH_5, CH_3};
  localparam msg_t MSG_LOGOUT = {SOH, CH_5, CH_EQ, CH_5, CH_3};

  function automatic logic [7:0] msg_byte(input state_t s, input logic [2:0] idx);
    case (s)
      S_SEND_HB:     msg_byte = MSG_HB[idx];
      S_SEND_LOGOUT: msg_byte = MSG_LOGOUT[idx];
      default:       msg_byte = MSG_LOGON[idx];
    endcase
  endfunction

endpackage

// File: rtl/fix_rx_parser.sv
// Inbound FIX stream scanner: pulses message_received one cycle after the SOH
// that closes a "10=" (checksum) field seen at a field start.
module fix_rx_parser
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       message_received
);

  rx_state_t st, st_nx;
  logic      hit;

  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      st               <= P_FIELD;
      message_received <= 1'b0;
    end else begin
      st               <= st_nx;
      message_received <= hit;
    end
  end

  // A mismatching SOH still marks the next byte as a field start.
  always_comb begin
    st_nx = st;
    hit   = 1'b0;
    if (valid) begin
      case (st)
        P_FIELD: st_nx = (data == CH_1)  ? P_TAG1  : (data == SOH) ? P_FIELD : P_SKIP;
        P_TAG1:  st_nx = (data == CH_0)  ? P_TAG2  : (data == SOH) ? P_FIELD : P_SKIP;
        P_TAG2:  st_nx = (data == CH_EQ) ? P_ARMED : (data == SOH) ? P_FIELD : P_SKIP;
        P_ARMED: if (data == SOH) begin
          hit   = 1'b1;
          st_nx = P_FIELD;
        end
        P_SKIP:  if (data == SOH) st_nx = P_FIELD;
        default: st_nx = P_FIELD;
      endcase
    end
  end

endmodule

// File: rtl/fix_engine.sv
// FIX session-layer engine: connect handshake with the TOE, byte-serial
// logon/heartbeat/logout transmission and inbound message detection.
module fix_engine
  import fix_pkg::*;
#(
  parameter int HOST_W       = 2,
  parameter int CONN_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              connect_i,
  input  logic [HOST_W-1:0] connect_to_host_i,
  input  logic              connected_i,
  input  logic [HOST_W-1:0] connected_host_addr_i,
  input  logic [7:0]        message_i,
  input  logic              valid_i,
  input  logic              new_message_i,
  output logic              connect_req_o,
  output logic              disconnect_o,
  output logic [HOST_W-1:0] connect_addr_o,
  output logic [HOST_W-1:0] disconnect_host_num_o,
  output logic              send_message_valid_o,
  output logic [7:0]        message_o,
  output logic              message_received_o
);

  localparam int CNT_W = $clog2(CONN_TIMEOUT + 1);

  state_t            state, state_nx;
  logic [HOST_W-1:0] host, host_nx;
  logic [2:0]        idx, idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              sending;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      host  <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      host  <= host_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  assign sending = (state == S_SEND_LOGON) || (state == S_SEND_HB) ||
                   (state == S_SEND_LOGOUT);

  always_comb begin
    state_nx = state;
    host_nx  = host;
    idx_nx   = '0;
    cnt_nx   = '0;
    case (state)
      S_IDLE: if (connect_i) begin
        host_nx  = connect_to_host_i;
        state_nx = S_CONN_REQ;
      end
      S_CONN_REQ: state_nx = S_WAIT_CONN;
      // cnt counts cycles already spent waiting; the last one gives up.
      S_WAIT_CONN: begin
        cnt_nx = cnt + 1'b1;
        if (!connect_i)                                         state_nx = S_DISCONNECT;
        else if (connected_i && connected_host_addr_i == host)  state_nx = S_SEND_LOGON;
        else if (cnt == CNT_W'(CONN_TIMEOUT - 1))               state_nx = S_DISCONNECT;
      end
      S_SEND_LOGON, S_SEND_HB, S_SEND_LOGOUT: begin
        idx_nx = idx + 3'd1;
        if (idx == 3'(MSG_LEN - 1)) begin
          idx_nx   = '0;
          state_nx = (state == S_SEND_LOGOUT) ? S_DISCONNECT : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!connected_i)       state_nx = S_IDLE;
        else if (!connect_i)    state_nx = S_SEND_LOGOUT;
        else if (new_message_i) state_nx = S_SEND_HB;
      end
      S_DISCONNECT: state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  assign connect_req_o         = (state == S_CONN_REQ);
  assign disconnect_o          = (state == S_DISCONNECT);
  assign disconnect_host_num_o = disconnect_o ? host : '0;
  assign connect_addr_o        = host;
  assign send_message_valid_o  = sending;
  assign message_o             = sending ? msg_byte(state, idx) : 8'h00;

  fix_rx_parser u_rx (
    .clk              (clk),
    .rst              (rst),
    .enable           (sending || state == S_ACTIVE),
    .data             (message_i),
    .valid            (valid_i),
    .message_received (message_received_o)
  );

endmodule

// File: tb/tb_fix_engine.sv
// Randomized self-checking bench for fix_engine: session sequencing checked
// against byte templates, inbound stream checked against a field-level model.
module tb_fix_engine;
  localparam int HOST_W       = 2;
  localparam int CONN_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              connect_i = 1'b0;
  logic [HOST_W-1:0] connect_to_host_i = '0;
  logic              connected_i = 1'b0;
  logic [HOST_W-1:0] connected_host_addr_i = '0;
  logic [7:0]        message_i = '0;
  logic              valid_i = 1'b0;
  logic              new_message_i = 1'b0;
  logic              connect_req_o, disconnect_o, send_message_valid_o, message_received_o;
  logic [HOST_W-1:0] connect_addr_o, disconnect_host_num_o;
  logic [7:0]        message_o;

  fix_engine #(.HOST_W(HOST_W), .CONN_TIMEOUT(CONN_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .connect_i(connect_i), .connect_to_host_i(connect_to_host_i),
    .connected_i(connected_i), .connected_host_addr_i(connected_host_addr_i),
    .message_i(message_i), .valid_i(valid_i), .new_message_i(new_message_i),
    .connect_req_o(connect_req_o), .disconnect_o(disconnect_o),
    .connect_addr_o(connect_addr_o), .disconnect_host_num_o(disconnect_host_num_o),
    .send_message_valid_o(send_message_valid_o), .message_o(message_o),
    .message_received_o(message_received_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Wire order: "35=A"SOH, "35=0"SOH, "35=5"SOH
  logic [7:0] tmpl [3][5] = '{'{8'h33, 8'h35, 8'h3D, 8'h41, 8'h01},
                              '{8'h33, 8'h35, 8'h3D, 8'h30, 8'h01},
                              '{8'h33, 8'h35, 8'h3D, 8'h35, 8'h01}};
  string tname [3] = '{"logon", "hb", "logout"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {16'h0, connect_req_o, disconnect_o, connect_addr_o, disconnect_host_num_o,
            send_message_valid_o, message_o, message_received_o};
  endfunction

  function automatic logic [31:0] vec(input logic req, input logic disc,
                                      input logic [1:0] addr, input logic [1:0] dh,
                                      input logic v, input logic [7:0] m, input logic r);
    return {16'h0, req, disc, addr, dh, v, m, r};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Expects byte 0 of template k visible now; leaves on the cycle after byte 4.
  task automatic expect_msg(input int k, input logic [1:0] h);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s b%0d", tname[k], i), outs(), vec(0, 0, h, 0, 1, tmpl[k][i], 0));
      step();
    end
  endtask

  // Connect to h, hold off with non-matching TOE status, then confirm.
  task automatic open_sess(input logic [1:0] h, input bit full);
    int d;
    connect_i = 1'b1; connect_to_host_i = h;
    step();
    chk("conn_req", outs(), vec(1, 0, h, 0, 0, 0, 0));
    connect_to_host_i = 2'($urandom);
    d = $urandom_range(1, 4);
    for (int i = 0; i < d; i++) begin
      connected_i = 1'($urandom);
      connected_host_addr_i = h ^ 2'($urandom_range(1, 3));
      step();
      chk("wait_conn", outs(), vec(0, 0, h, 0, 0, 0, 0));
    end
    connected_i = 1'b1; connected_host_addr_i = h;
    step();
    if (full) expect_msg(0, h);
  endtask

  task automatic heartbeat(input logic [1:0] h);
    chk("active_idle", outs(), vec(0, 0, h, 0, 0, 0, 0));
    new_message_i = 1'b1;
    step();
    new_message_i = 1'b0;
    expect_msg(1, h);
  endtask

  task automatic close_sess(input logic [1:0] h);
    connect_i = 1'b0;
    step();
    expect_msg(2, h);
    chk("disconnect", outs(), vec(0, 1, h, h, 0, 0, 0));
    step();
    chk("after_disc", outs(), vec(0, 0, h, 0, 0, 0, 0));
    connected_i = 1'b0;
  endtask

  // Inbound stream: fields split on SOH; a field starting "10=" completes a message.
  task automatic rx_test(input logic [1:0] h);
    logic [7:0] bytes[$];
    bit         pulse[$];
    logic [7:0] f[$];
    int         exp_cnt = 0, got_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      f = {};
      if (n < 4) begin
        if (n % 2 == 0) f = {8'h33, 8'h35, 8'h3D, 8'h30};
        else            f = {8'h31, 8'h30, 8'h3D, 8'h31, 8'h32, 8'h33};
      end else begin
        case ($urandom_range(0, 5))
          0: f = {8'h31, 8'h30, 8'h3D};
          1: f = {8'h31, 8'h31, 8'h30, 8'h3D};
          2: f = {8'h33, 8'h35, 8'h3D, 8'h41};
          3: f = {8'h31};
          4: f = {8'h31, 8'h30};
          default: ;
        endcase
        for (int i = $urandom_range(0, 3); i > 0; i--) f.push_back(8'($urandom_range(2, 255)));
      end
      foreach (f[i]) begin bytes.push_back(f[i]); pulse.push_back(1'b0); end
      bytes.push_back(8'h01);
      pulse.push_back(f.size() >= 3 && f[0] == 8'h31 && f[1] == 8'h30 && f[2] == 8'h3D);
      if (pulse[$]) exp_cnt++;
    end
    foreach (bytes[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0; message_i = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'($urandom);
        step();
        chk("rx_gap", 32'(message_received_o), 32'd0);
      end
      valid_i = 1'b1; message_i = bytes[i];
      step();
      chk($sformatf("rx_byte%0d", i), 32'(message_received_o), 32'(pulse[i]));
      if (message_received_o) got_cnt++;
    end
    valid_i = 1'b0; message_i = '0;
    step();
    chk("rx_tail", outs(), vec(0, 0, h, 0, 0, 0, 0));
    chk("rx_count", 32'(got_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [1:0] h;
    int         w;

    // reset held, then released with no connect request
    step();
    chk("reset0", outs(), 32'd0);
    step();
    chk("reset1", outs(), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle", outs(), 32'd0);
    end

    // host 0: logon, heartbeat, logout
    open_sess(2'd0, 1);
    heartbeat(2'd0);
    close_sess(2'd0);

    // random sessions
    for (int it = 0; it < 4; it++) begin
      h = 2'($urandom);
      open_sess(h, 1);
      for (int k = $urandom_range(0, 2); k > 0; k--) heartbeat(h);
      close_sess(h);
    end

    // connection timeout with only a mismatched host answering
    connect_i = 1'b1; connect_to_host_i = 2'd2;
    connected_i = 1'b1; connected_host_addr_i = 2'd1;
    step();
    chk("to_req", outs(), vec(1, 0, 2, 0, 0, 0, 0));
    w = 0;
    while (!disconnect_o && w < 40) begin
      step();
      w++;
      if (!disconnect_o) chk("to_wait", 32'(send_message_valid_o), 32'd0);
    end
    chk("to_cycles", 32'(w), 32'(CONN_TIMEOUT + 1));
    chk("to_disc", outs(), vec(0, 1, 2, 2, 0, 0, 0));
    connect_i = 1'b0; connected_i = 1'b0;
    step();
    chk("to_idle", outs(), vec(0, 0, 2, 0, 0, 0, 0));

    // app withdraws while waiting for the TOE
    connect_i = 1'b1; connect_to_host_i = 2'd1;
    step();
    connect_i = 1'b0;
    step();
    step();
    chk("abort_disc", outs(), vec(0, 1, 1, 1, 0, 0, 0));
    step();

    // inbound message detection
    h = 2'($urandom);
    open_sess(h, 1);
    rx_test(h);
    close_sess(h);

    // reset during logon byte 2
    open_sess(2'd3, 0);
    step();
    step();
    chk("pre_rst_b2", outs(), vec(0, 0, 3, 0, 1, 8'h3D, 0));
    rst = 1'b0;
    step();
    chk("mid_rst", outs(), 32'd0);
    rst = 1'b1; connect_i = 1'b0; connected_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst", outs(), 32'd0);
    end

    // peer drop in ACTIVE wins over the app tearing down: no logout, no disconnect
    open_sess(2'd1, 1);
    connected_i = 1'b0; connect_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("peer_drop", outs(), vec(0, 0, 1, 0, 0, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
